// File: rtl/perceptron_trainer.sv
// perceptron_trainer: sequential training engine for a two-input perceptron neuron.
// It owns the w1/w2/wb weight registers and drives them, together with the current
// sample inputs, to an external neuron. It samples the neuron's 1-bit decision, compares
// it with the target label, and applies w += LR*(t-y)*x for each sample. It counts epochs
// until an error-free epoch occurs or MAX_EPOCHS is reached.
//
// Numbers are sign-magnitude, MSB = sign, Q(Q_M).(Q_N).
//
// Optional feature, enabled by defining TRAINER_WEIGHT_LOAD_EN:
//   Adds ports wload_valid, wload_w1, wload_w2 and wload_wb. In IDLE or DONE these load
//   all three weights; start wins if both arrive in the same cycle.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start                         begin training (honoured only in IDLE/DONE)
//   sample_valid/ready            sample handshake; sample_x1/x2/target carry the sample
//   x1_out, x2_out                sample inputs to the neuron (0 or 1.0)
//   w1_out, w2_out, wb_out        weights to the neuron
//   neuron_out                    neuron decision
//   busy, done, converged         status
//   epoch_count, error_count      completed epochs / errors in current or last epoch
module perceptron_trainer #(
   parameter int unsigned SIGN        = 1,
   parameter int unsigned Q_M         = 15,
   parameter int unsigned Q_N         = 16,
   parameter logic [SIGN+Q_M+Q_N-1:0] LR = 32'h0000_8000,
   parameter int unsigned NUM_SAMPLES = 4,
   parameter int unsigned MAX_EPOCHS  = 16,
   parameter int unsigned NEURON_LAT  = 1,
   localparam int unsigned W  = SIGN + Q_M + Q_N,
   localparam int unsigned EW = $clog2(MAX_EPOCHS + 1),
   localparam int unsigned CW = $clog2(NUM_SAMPLES + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          sample_valid,
   output logic          sample_ready,
   input  logic          sample_x1,
   input  logic          sample_x2,
   input  logic          sample_target,
   output logic [W-1:0]  x1_out,
   output logic [W-1:0]  x2_out,
   output logic [W-1:0]  w1_out,
   output logic [W-1:0]  w2_out,
   output logic [W-1:0]  wb_out,
   input  logic          neuron_out,
`ifdef TRAINER_WEIGHT_LOAD_EN
   input  logic          wload_valid,
   input  logic [W-1:0]  wload_w1,
   input  logic [W-1:0]  wload_w2,
   input  logic [W-1:0]  wload_wb,
`endif
   output logic          busy,
   output logic          done,
   output logic          converged,
   output logic [EW-1:0] epoch_count,
   output logic [CW-1:0] error_count
);

   localparam int unsigned LW = (NEURON_LAT < 2) ? 1 : $clog2(NEURON_LAT);
   localparam logic [W-1:0] ONE = {{(SIGN + Q_M - 1){1'b0}}, 1'b1, {Q_N{1'b0}}};
   localparam logic [W-1:0] NEG_LR = {~LR[W-1], LR[W-2:0]};

   typedef enum logic [2:0] {
      StIdle,
      StWaitSample,
      StEval,
      StUpdate,
      StEpochEnd,
      StDone
   } state_e;

   state_e state_q, state_d;
   logic [W-1:0]  w1_q, w1_d, w2_q, w2_d, wb_q, wb_d;
   logic [W-1:0]  x1_q, x1_d, x2_q, x2_d;
   logic          tgt_q, tgt_d, y_q, y_d;
   logic          conv_q, conv_d;
   logic [EW-1:0] ep_q, ep_d;
   logic [CW-1:0] err_q, err_d;
   logic [CW-1:0] smp_q, smp_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [W-1:0]  delta;

   // Sign-magnitude add: saturates on same-sign overflow, never yields -0.
   function automatic logic [W-1:0] sm_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] sum;
      logic [W-2:0] ma, mb, mr;
      logic         sr;
      ma  = a[W-2:0];
      mb  = b[W-2:0];
      sum = '0;
      if (a[W-1] == b[W-1]) begin
         sum = {1'b0, ma} + {1'b0, mb};
         mr  = sum[W-1] ? '1 : sum[W-2:0];
         sr  = a[W-1];
      end else if (ma >= mb) begin
         mr = ma - mb;
         sr = a[W-1];
      end else begin
         mr = mb - ma;
         sr = b[W-1];
      end
      if (mr == '0) sr = 1'b0;
      return {sr, mr};
   endfunction

   // err = +1 when the target is 1 (and y is 0), -1 otherwise.
   assign delta = tgt_q ? LR : NEG_LR;

   always_comb begin
      state_d = state_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      wb_d    = wb_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      tgt_d   = tgt_q;
      y_d     = y_q;
      conv_d  = conv_q;
      ep_d    = ep_q;
      err_d   = err_q;
      smp_d   = smp_q;
      lat_d   = lat_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               ep_d    = '0;
               err_d   = '0;
               smp_d   = '0;
               conv_d  = 1'b0;
               state_d = StWaitSample;
            end
`ifdef TRAINER_WEIGHT_LOAD_EN
            else if (wload_valid) begin
               w1_d = wload_w1;
               w2_d = wload_w2;
               wb_d = wload_wb;
            end
`endif
         end
         StWaitSample: begin
            if (sample_valid) begin
               x1_d    = sample_x1 ? ONE : '0;
               x2_d    = sample_x2 ? ONE : '0;
               tgt_d   = sample_target;
               lat_d   = '0;
               state_d = StEval;
            end
         end
         StEval: begin
            if (lat_q == LW'(NEURON_LAT - 1)) begin
               y_d     = neuron_out;
               state_d = StUpdate;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         StUpdate: begin
            if (tgt_q != y_q) begin
               if (|x1_q) w1_d = sm_add(w1_q, delta);
               if (|x2_q) w2_d = sm_add(w2_q, delta);
               wb_d  = sm_add(wb_q, delta);
               err_d = err_q + 1'b1;
            end
            smp_d   = smp_q + 1'b1;
            state_d = (smp_q == CW'(NUM_SAMPLES - 1)) ? StEpochEnd : StWaitSample;
         end
         StEpochEnd: begin
            ep_d = ep_q + 1'b1;
            if (err_q == '0) begin
               conv_d  = 1'b1;
               state_d = StDone;
            end else if (ep_q == EW'(MAX_EPOCHS - 1)) begin
               conv_d  = 1'b0;
               state_d = StDone;
            end else begin
               err_d   = '0;
               smp_d   = '0;
               state_d = StWaitSample;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         w1_q    <= '0;
         w2_q    <= '0;
         wb_q    <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         tgt_q   <= 1'b0;
         y_q     <= 1'b0;
         conv_q  <= 1'b0;
         ep_q    <= '0;
         err_q   <= '0;
         smp_q   <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         wb_q    <= wb_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         tgt_q   <= tgt_d;
         y_q     <= y_d;
         conv_q  <= conv_d;
         ep_q    <= ep_d;
         err_q   <= err_d;
         smp_q   <= smp_d;
         lat_q   <= lat_d;
      end
   end

   assign sample_ready = (state_q == StWaitSample);
   assign busy         = (state_q == StWaitSample) || (state_q == StEval) ||
                         (state_q == StUpdate) || (state_q == StEpochEnd);
   assign done         = (state_q == StDone);
   assign converged    = conv_q;
   assign epoch_count  = ep_q;
   assign error_count  = err_q;
   assign x1_out       = x1_q;
   assign x2_out       = x2_q;
   assign w1_out       = w1_q;
   assign w2_out       = w2_q;
   assign wb_out       = wb_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
module tb_perceptron_trainer;

   localparam int unsigned NS   = 4;
   localparam int unsigned MAXE = 3;
   localparam longint      LRV  = 32768;
   localparam longint      SATV = 64'sd2147483647;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic        sample_x1 = 1'b0;
   logic        sample_x2 = 1'b0;
   logic        sample_target = 1'b0;
   logic [31:0] x1_out, x2_out, w1_out, w2_out, wb_out;
   logic        neuron_out = 1'b0;
   logic        busy, done, converged;
   logic [1:0]  epoch_count;
   logic [2:0]  error_count;
`ifdef TRAINER_WEIGHT_LOAD_EN
   logic        wload_valid = 1'b0;
   logic [31:0] wload_w1 = '0, wload_w2 = '0, wload_wb = '0;
`endif

   perceptron_trainer #(
      .NUM_SAMPLES (NS),
      .MAX_EPOCHS  (MAXE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .sample_valid  (sample_valid),
      .sample_ready  (sample_ready),
      .sample_x1     (sample_x1),
      .sample_x2     (sample_x2),
      .sample_target (sample_target),
      .x1_out        (x1_out),
      .x2_out        (x2_out),
      .w1_out        (w1_out),
      .w2_out        (w2_out),
      .wb_out        (wb_out),
      .neuron_out    (neuron_out),
`ifdef TRAINER_WEIGHT_LOAD_EN
      .wload_valid   (wload_valid),
      .wload_w1      (wload_w1),
      .wload_w2      (wload_w2),
      .wload_wb      (wload_wb),
`endif
      .busy          (busy),
      .done          (done),
      .converged     (converged),
      .epoch_count   (epoch_count),
      .error_count   (error_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: weights as plain signed integers in raw fixed-point units.
   longint m_w1, m_w2, m_wb;
   int     m_err, m_ep, m_smp;
   bit     m_busy, m_done, m_conv;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] to_sm(input longint v);
      logic [30:0] m;
      if (v < 0) begin
         m = 31'(-v);
         return {1'b1, m};
      end
      m = 31'(v);
      return {1'b0, m};
   endfunction

   function automatic longint from_sm(input logic [31:0] s);
      longint m;
      m = longint'(s[30:0]);
      return s[31] ? -m : m;
   endfunction

   function automatic longint sat(input longint v);
      if (v > SATV) return SATV;
      if (v < -SATV) return -SATV;
      return v;
   endfunction

   task automatic model_reset();
      m_w1 = 0; m_w2 = 0; m_wb = 0;
      m_err = 0; m_ep = 0; m_smp = 0;
      m_busy = 0; m_done = 0; m_conv = 0;
   endtask

   task automatic check_weights(input string tag);
      chk({tag, "_w1"}, w1_out, to_sm(m_w1));
      chk({tag, "_w2"}, w2_out, to_sm(m_w2));
      chk({tag, "_wb"}, wb_out, to_sm(m_wb));
      chk({tag, "_errcnt"}, error_count, m_err);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ready"}, sample_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_conv"}, converged, 0);
      chk({tag, "_epoch"}, epoch_count, 0);
      chk({tag, "_errcnt"}, error_count, 0);
      chk({tag, "_w1"}, w1_out, 0);
      chk({tag, "_w2"}, w2_out, 0);
      chk({tag, "_wb"}, wb_out, 0);
      chk({tag, "_x1"}, x1_out, 0);
      chk({tag, "_x2"}, x2_out, 0);
   endtask

   task automatic pulse_start(input string tag);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (!m_busy) begin
         m_err = 0; m_ep = 0; m_smp = 0;
         m_done = 0; m_conv = 0; m_busy = 1;
      end
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_epoch"}, epoch_count, m_ep);
      chk({tag, "_errcnt"}, error_count, m_err);
      chk({tag, "_ready"}, sample_ready, 1);
   endtask

   // One full sample: handshake, neuron decision y, update, and epoch end if reached.
   task automatic do_sample(input bit x1, input bit x2, input bit t, input bit y);
      int k;
      @(negedge clk);
      sample_valid  = 1'b1;
      sample_x1     = x1;
      sample_x2     = x2;
      sample_target = t;
      neuron_out    = y;
      k = 0;
      while (!sample_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!sample_ready) begin
         chk("accept_timeout", sample_ready, 1);
         sample_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      chk("eval_ready", sample_ready, 0);
      chk("eval_x1", x1_out, x1 ? 32'h0001_0000 : 32'h0);
      chk("eval_x2", x2_out, x2 ? 32'h0001_0000 : 32'h0);
      @(posedge clk); #1;
      chk("update_ready", sample_ready, 0);
      chk("update_busy", busy, 1);
      @(posedge clk); #1;
      sample_valid = 1'b0;
      if (t != y) begin
         longint e;
         e = t ? LRV : -LRV;
         if (x1) m_w1 = sat(m_w1 + e);
         if (x2) m_w2 = sat(m_w2 + e);
         m_wb = sat(m_wb + e);
         m_err++;
      end
      m_smp++;
      check_weights("upd");
      if (m_smp == NS) begin
         @(posedge clk); #1;
         m_ep++;
         if (m_err == 0) begin
            m_conv = 1; m_done = 1; m_busy = 0;
         end else if (m_ep == MAXE) begin
            m_conv = 0; m_done = 1; m_busy = 0;
         end else begin
            m_err = 0; m_smp = 0;
         end
         chk("ep_epoch", epoch_count, m_ep);
         chk("ep_done", done, m_done);
         chk("ep_conv", converged, m_conv);
         chk("ep_busy", busy, m_busy);
         chk("ep_errcnt", error_count, m_err);
         chk("ep_ready", sample_ready, m_busy);
      end
   endtask

   task automatic random_sample(input int mode);
      bit x1, x2, t, y;
      x1 = 1'($urandom_range(0, 1));
      x2 = 1'($urandom_range(0, 1));
      t  = 1'($urandom_range(0, 1));
      case (mode)
         0:       y = t;
         1:       y = ~t;
         default: y = 1'($urandom_range(0, 1));
      endcase
      do_sample(x1, x2, t, y);
   endtask

   initial begin
      int guard;
      model_reset();
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      pulse_start("start1");
      do_sample(1'b1, 1'b0, 1'b1, 1'b0);
      chk("plan1_w1", w1_out, 32'h0000_8000);
      chk("plan1_w2", w2_out, 32'h0000_0000);
      chk("plan1_wb", wb_out, 32'h0000_8000);
      chk("plan1_err", error_count, 1);
      do_sample(1'b0, 1'b1, 1'b0, 1'b1);
      chk("plan2_w1", w1_out, 32'h0000_8000);
      chk("plan2_w2", w2_out, 32'h8000_8000);
      chk("plan2_wb", wb_out, 32'h0000_0000);
      random_sample(2);
      random_sample(2);
      chk("epoch1_count", epoch_count, 1);

      // start while busy must be ignored
      pulse_start("midstart");
      chk("midstart_epoch", epoch_count, 1);

      guard = 0;
      while (!m_done && guard < 16) begin
         random_sample(2);
         guard++;
      end
      chk("run1_done", done, 1);

      // Never-correct neuron: all MAXE epochs used.
      pulse_start("start_wrong");
      for (int i = 0; i < NS * MAXE; i++) random_sample(1);
      chk("wrong_done", done, 1);
      chk("wrong_conv", converged, 0);
      chk("wrong_epoch", epoch_count, 3);
      chk("wrong_err", error_count, 4);

      // Always-correct neuron: converges after one epoch.
      pulse_start("start_right");
      for (int i = 0; i < NS; i++) random_sample(0);
      chk("right_done", done, 1);
      chk("right_conv", converged, 1);
      chk("right_epoch", epoch_count, 1);
      chk("right_err", error_count, 0);
      chk("right_busy", busy, 0);

      // Reset during EVAL discards the partial update.
      pulse_start("start_rst");
      random_sample(1);
      @(negedge clk);
      sample_valid  = 1'b1;
      sample_x1     = 1'b1;
      sample_x2     = 1'b1;
      sample_target = 1'b1;
      neuron_out    = 1'b0;
      @(posedge clk); #1;
      chk("rst_eval_ready", sample_ready, 0);
      rst_n = 1'b0;
      sample_valid = 1'b0;
      #1;
      model_reset();
      check_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int r = 0; r < 3; r++) begin
         pulse_start("rand_start");
         guard = 0;
         while (!m_done && guard < NS * MAXE) begin
            random_sample(2);
            guard++;
         end
         chk("rand_done", done, 1);
         chk("rand_weights_w1", w1_out, to_sm(m_w1));
      end

`ifdef TRAINER_WEIGHT_LOAD_EN
      @(negedge clk);
      wload_valid = 1'b1;
      wload_w1 = 32'h7FFF_FFFF;
      wload_w2 = 32'h0000_0000;
      wload_wb = 32'h8000_0000;
      @(negedge clk);
      wload_valid = 1'b0;
      m_w1 = from_sm(32'h7FFF_FFFF);
      m_w2 = 0;
      m_wb = from_sm(32'h8000_0000);
      chk("load_w1", w1_out, 32'h7FFF_FFFF);
      chk("load_wb", wb_out, 32'h8000_0000);
      pulse_start("start_load");
      do_sample(1'b1, 1'b0, 1'b1, 1'b0);
      chk("sat_w1", w1_out, 32'h7FFF_FFFF);
      chk("negzero_wb", wb_out, 32'h0000_8000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
- Sequential training engine for the two-input perceptron neuron; the backward/learning direction of the forward neuron datapath.
- Owns the w1/w2/wb weight registers and drives them, plus the current sample inputs, to the neuron.
- Samples the neuron's 1-bit decision, compares it with the target label and applies the perceptron rule w += LR·(t−y)·x per sample.
- Counts epochs until an error-free epoch (converged) or MAX_EPOCHS is reached.

Parameters:
SIGN, 1, sign bit width of the sign-magnitude fixed-point word
Q_M, 15, integer magnitude bits
Q_N, 16, fractional bits (W = SIGN+Q_M+Q_N = 32)
LR, 32'h0000_8000, learning rate (+0.5), positive sign-magnitude
NUM_SAMPLES, 4, samples per epoch
MAX_EPOCHS, 16, epoch limit
NEURON_LAT, 1, cycles between driving x/w and sampling neuron_out (≥1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: clear counters, begin training (IDLE/DONE only)
sample_valid  in  1  training sample present
sample_ready  out  1  trainer accepts sample this cycle
sample_x1  in  1  binary input 1
sample_x2  in  1  binary input 2
sample_target  in  1  expected label
x1_out  out  W  x1 to neuron, Q16.16 (0 or 1.0 = 32'h0001_0000)
x2_out  out  W  x2 to neuron, same encoding
w1_out  out  W  weight 1
w2_out  out  W  weight 2
wb_out  out  W  bias weight
neuron_out  in  1  neuron decision
busy  out  1  training in progress
done  out  1  training finished, held until next start
converged  out  1  last completed epoch had zero errors (valid with done)
epoch_count  out  $clog2(MAX_EPOCHS+1)  completed epochs
error_count  out  $clog2(NUM_SAMPLES+1)  errors in current/last epoch

Behaviour:
- Reset:
  - All weights, x outputs and counters = 0.
  - State IDLE.
  - sample_ready, busy, done, converged = 0.
- States: IDLE, WAIT_SAMPLE, EVAL, UPDATE, EPOCH_END, DONE.
- IDLE/DONE + start: clear epoch_count, error_count, sample counter, done, converged; go to WAIT_SAMPLE. Weights are NOT cleared by start.
- start in any other state: ignored.
- WAIT_SAMPLE:
  - sample_ready = 1.
  - Transfer on sample_valid && sample_ready: register x1/x2 (as 0 or 1.0) and target; go to EVAL.
- EVAL: sample_ready = 0; hold NEURON_LAT cycles, then register neuron_out; go to UPDATE.
- UPDATE (1 cycle):
  - err = target − y.
  - err = 0: no change.
  - err = +1: w1 += LR if x1; w2 += LR if x2; wb += LR.
  - err = −1: same weight selection, subtracting LR.
  - On err ≠ 0, error_count +1.
  - Sample counter +1; reaching NUM_SAMPLES → EPOCH_END, else WAIT_SAMPLE.
- Per-sample latency: 1 (accept) + NEURON_LAT + 1 (update) cycles.
- Arithmetic (sign-magnitude, MSB = sign):
  - Same signs: add magnitudes, saturate to 31'h7FFF_FFFF.
  - Different signs: subtract smaller magnitude from larger; result takes the larger operand's sign.
  - Zero result always encoded +0 (32'h0); −0 never produced.
- EPOCH_END (1 cycle):
  - epoch_count +1.
  - error_count == 0 → converged = 1, DONE.
  - Else if epoch_count+1 == MAX_EPOCHS → converged = 0, DONE.
  - Else clear error_count and sample counter, go to WAIT_SAMPLE.
- error_count retains the last epoch's value in DONE.
- DONE: done = 1, busy = 0, weights frozen and still driven.
- busy = 1 in WAIT_SAMPLE, EVAL, UPDATE, EPOCH_END.
- Asynchronous reset mid-operation: immediate return to reset values; partial update discarded.

Optional Feature:
TRAINER_WEIGHT_LOAD_EN
- Defined: adds ports wload_valid (in, 1), wload_w1/wload_w2/wload_wb (in, W).
  - wload_valid in IDLE or DONE loads all three weights next edge.
  - Ignored while busy.
  - start has priority if asserted in the same cycle.
- Undefined: ports absent; weights start at 0 after reset and only change via training.

Test Plan:
- Reset, start, sample (x1=1, x2=0, t=1), bench drives neuron_out=0 → after UPDATE: w1=32'h0000_8000, w2=0, wb=32'h0000_8000, error_count=1.
- Continue with sample (x1=0, x2=1, t=0), neuron_out=1 → w2=32'h8000_8000, wb=32'h0000_0000 (+0), w1 unchanged.
- With TRAINER_WEIGHT_LOAD_EN:
  - Load w1=32'h7FFF_FFFF; sample x1=1, t=1, neuron_out=0 → w1 stays 32'h7FFF_FFFF (saturated).
  - Load wb=32'h8000_0000 (−0 input); err=+1 → wb=32'h0000_8000.
- NUM_SAMPLES=4, bench neuron_out always equals target → after 4 samples done=1, converged=1, epoch_count=1, error_count=0, busy=0.
- MAX_EPOCHS=3, neuron_out always ≠ target → done after 12 samples, converged=0, epoch_count=3, error_count=4.
- Assert rst_n low during EVAL; release; assert start while busy after restart → all outputs 0 after reset; mid-run start ignored (epoch_count not cleared); sample_ready low in EVAL, exactly one transfer per sample.
